// File: rtl/nr_sequencer.sv
// rtl/nr_sequencer.sv - multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control with memory timeout
module nr_sequencer #(
  parameter int TMO = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        alu_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        ctl_en,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        err,
  output logic [15:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  localparam logic [3:0] OP_SLP = 4'b0000;
  localparam logic [3:0] OP_BRQ = 4'b0001;
  localparam logic [3:0] OP_BRF = 4'b0010;
  localparam logic [3:0] OP_JR  = 4'b1011;
  localparam logic [3:0] OP_LW  = 4'b1110;
  localparam logic [3:0] OP_SW  = 4'b1111;

  state_t          state, next;
  logic [3:0]      op_q;
  logic [CW-1:0]   tmo_cnt;
  logic [15:0]     instret_q;
  logic            retire;
  logic            waiting;
  logic            tmo_hit;

  // A cycle spent in a handshake state without ack; the TMO-th such cycle trips the timeout.
  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
  assign tmo_hit = (TMO != 0) && waiting && (tmo_cnt == CW'(TMO - 1));
  assign instret = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (run) next = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      next = S_DECODE;
        else if (tmo_hit) next = S_ERR;
      end
      S_DECODE: next = (opcode == OP_SLP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:         next = S_MEM;
          OP_BRQ, OP_BRF, OP_JR: next = S_FETCH;
          default:              next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ack)      next = (op_q == OP_SW) ? S_FETCH : S_WB;
        else if (tmo_hit) next = S_ERR;
      end
      S_WB:     next = S_FETCH;
      S_HALT:   if (run) next = S_FETCH;
      S_ERR:    next = S_ERR;
      default:  next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    ir_we   = 1'b0;
    ctl_en  = 1'b0;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    retire  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_DECODE: begin
        ctl_en = 1'b1;
        retire = (opcode == OP_SLP);
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if ((op_q == OP_BRQ) || (op_q == OP_BRF)) begin
          pc_load = alu_flag;
          pc_inc  = !alu_flag;
          retire  = 1'b1;
        end else if (op_q == OP_JR) begin
          pc_load = 1'b1;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ack && (op_q == OP_SW)) begin
          pc_inc = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_inc = 1'b1;
        retire = 1'b1;
      end
      // Waking skips over the slp word itself.
      S_HALT: begin
        halted = 1'b1;
        pc_inc = run;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      tmo_cnt   <= '0;
      instret_q <= '0;
    end else begin
      if (state == S_DECODE) op_q <= opcode;
      if (waiting && (TMO != 0)) tmo_cnt <= tmo_cnt + 1'b1;
      else                       tmo_cnt <= '0;
      if (retire) instret_q <= instret_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_nr_sequencer.sv
// tb/tb_nr_sequencer.sv - directed table, hand sequences and randomized instruction stream for nr_sequencer
module tb_nr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        alu_flag = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_we, ctl_en, alu_en, rf_we, pc_inc, pc_load, halted, err;
  logic [15:0] instret;
  logic [10:0] outs;

  nr_sequencer #(.TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_flag(alu_flag), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .ctl_en(ctl_en),
    .alu_en(alu_en), .rf_we(rf_we), .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
    .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, mem_sel, ir_we, ctl_en, alu_en, rf_we, pc_inc, pc_load, halted, err};

  localparam logic [10:0] REQ = 11'h400, WE  = 11'h200, SEL = 11'h100, IRW = 11'h080;
  localparam logic [10:0] CTL = 11'h040, ALU = 11'h020, RFW = 11'h010, INC = 11'h008;
  localparam logic [10:0] LD  = 11'h004, HLT = 11'h002, ERB = 11'h001, NONE = 11'h000;

  typedef struct {
    logic        ack;
    logic        run;
    logic [3:0]  op;
    logic        flag;
    logic [10:0] exp;
    logic [15:0] ir;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  vec_t tbl[$];
  vec_t q[$];
  logic [15:0] mi;

  function automatic vec_t mk(logic a, logic r, logic [3:0] o, logic f, logic [10:0] e, logic [15:0] i);
    return '{a, r, o, f, e, i};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ro();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    mem_ack  = v.ack;
    run      = v.run;
    opcode   = v.op;
    alu_flag = v.flag;
    #1;
    nvec++;
    if (outs !== v.exp || instret !== v.ir) begin
      nmis++;
      $display("FAIL %s vec %0d: outputs=%b instret=%h, expected outputs=%b instret=%h",
               tag, nvec, outs, instret, v.exp, v.ir);
    end
  endtask

  task automatic check_reset(input string tag);
    nvec++;
    if (outs !== NONE || instret !== 16'h0000) begin
      nmis++;
      $display("FAIL %s: outputs=%b instret=%h, expected outputs=%b instret=0000", tag, outs, instret, NONE);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 4'h0; alu_flag = 1'b0;
    #1;
    check_reset("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expands one instruction into its expected per-cycle trace from the phase rules.
  task automatic gen_instr();
    logic [3:0] op;
    logic f;
    int sel, df;
    sel = $urandom_range(0, 9);
    case (sel)
      0: op = 4'h0;
      1: op = 4'h1;
      2: op = 4'h2;
      3: op = 4'hB;
      4: op = 4'hE;
      5: op = 4'hF;
      default: op = 4'($urandom_range(3, 10));
    endcase
    df = $urandom_range(0, 5);
    for (int k = 0; k < df; k++) q.push_back(mk(1'b0, rb(), ro(), rb(), REQ, mi));
    q.push_back(mk(1'b1, rb(), ro(), rb(), REQ | IRW, mi));
    q.push_back(mk(rb(), rb(), op, rb(), CTL, mi));
    if (op == 4'h0) begin
      mi = mi + 16'd1;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) q.push_back(mk(rb(), 1'b0, ro(), rb(), HLT, mi));
      q.push_back(mk(rb(), 1'b1, ro(), rb(), HLT | INC, mi));
      return;
    end
    f = rb();
    if (op == 4'h1 || op == 4'h2) begin
      q.push_back(mk(rb(), rb(), ro(), f, ALU | (f ? LD : INC), mi));
      mi = mi + 16'd1;
    end else if (op == 4'hB) begin
      q.push_back(mk(rb(), rb(), ro(), f, ALU | LD, mi));
      mi = mi + 16'd1;
    end else if (op == 4'hE || op == 4'hF) begin
      logic [10:0] mb;
      mb = REQ | SEL | ((op == 4'hF) ? WE : NONE);
      q.push_back(mk(rb(), rb(), ro(), f, ALU, mi));
      df = $urandom_range(0, 6);
      for (int k = 0; k < df; k++) q.push_back(mk(1'b0, rb(), ro(), rb(), mb, mi));
      if (op == 4'hF) begin
        q.push_back(mk(1'b1, rb(), ro(), rb(), mb | INC, mi));
        mi = mi + 16'd1;
      end else begin
        q.push_back(mk(1'b1, rb(), ro(), rb(), mb, mi));
        q.push_back(mk(rb(), rb(), ro(), rb(), RFW | INC, mi));
        mi = mi + 16'd1;
      end
    end else begin
      q.push_back(mk(rb(), rb(), ro(), f, ALU, mi));
      q.push_back(mk(rb(), rb(), ro(), rb(), RFW | INC, mi));
      mi = mi + 16'd1;
    end
  endtask

  initial begin
    // add, branch taken/not taken, sw with 3-cycle ack, jr, lw, slp with halt and wake
    tbl.push_back(mk(0, 0, 4'h0, 0, NONE,            16'd0));
    tbl.push_back(mk(0, 1, 4'h0, 0, NONE,            16'd0));
    tbl.push_back(mk(0, 0, 4'h5, 0, REQ,             16'd0));
    tbl.push_back(mk(1, 0, 4'h5, 0, REQ | IRW,       16'd0));
    tbl.push_back(mk(0, 1, 4'h3, 0, CTL,             16'd0));
    tbl.push_back(mk(0, 1, 4'hF, 1, ALU,             16'd0));
    tbl.push_back(mk(1, 1, 4'h0, 0, RFW | INC,       16'd0));
    tbl.push_back(mk(1, 1, 4'h0, 0, REQ | IRW,       16'd1));
    tbl.push_back(mk(0, 0, 4'h1, 0, CTL,             16'd1));
    tbl.push_back(mk(0, 0, 4'h3, 1, ALU | LD,        16'd1));
    tbl.push_back(mk(1, 0, 4'h3, 0, REQ | IRW,       16'd2));
    tbl.push_back(mk(0, 0, 4'h1, 1, CTL,             16'd2));
    tbl.push_back(mk(0, 0, 4'h0, 0, ALU | INC,       16'd2));
    tbl.push_back(mk(1, 0, 4'h0, 0, REQ | IRW,       16'd3));
    tbl.push_back(mk(0, 0, 4'hF, 0, CTL,             16'd3));
    tbl.push_back(mk(0, 0, 4'h3, 0, ALU,             16'd3));
    tbl.push_back(mk(0, 1, 4'h3, 0, REQ | WE | SEL,  16'd3));
    tbl.push_back(mk(0, 0, 4'h3, 0, REQ | WE | SEL,  16'd3));
    tbl.push_back(mk(0, 0, 4'h3, 0, REQ | WE | SEL,  16'd3));
    tbl.push_back(mk(1, 0, 4'h3, 0, REQ | WE | SEL | INC, 16'd3));
    tbl.push_back(mk(1, 0, 4'h3, 0, REQ | IRW,       16'd4));
    tbl.push_back(mk(0, 0, 4'hB, 0, CTL,             16'd4));
    tbl.push_back(mk(0, 0, 4'h0, 0, ALU | LD,        16'd4));
    tbl.push_back(mk(1, 0, 4'h0, 0, REQ | IRW,       16'd5));
    tbl.push_back(mk(0, 0, 4'hE, 0, CTL,             16'd5));
    tbl.push_back(mk(0, 0, 4'h0, 0, ALU,             16'd5));
    tbl.push_back(mk(1, 0, 4'h0, 0, REQ | SEL,       16'd5));
    tbl.push_back(mk(0, 0, 4'h0, 0, RFW | INC,       16'd5));
    tbl.push_back(mk(1, 0, 4'h0, 0, REQ | IRW,       16'd6));
    tbl.push_back(mk(0, 0, 4'h0, 0, CTL,             16'd6));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 0, 4'h0, 1, HLT, 16'd7));
    tbl.push_back(mk(0, 1, 4'h0, 0, HLT | INC,       16'd7));
    tbl.push_back(mk(0, 0, 4'h0, 0, REQ,             16'd7));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table");

    // Timeout: 15 waiting cycles, then ERR ignores run and ack until reset.
    do_reset();
    apply(mk(0, 1, 4'h0, 0, NONE, 16'd0), "tmo_start");
    for (int k = 0; k < 15; k++) apply(mk(0, rb(), ro(), rb(), REQ, 16'd0), "tmo_wait");
    for (int k = 0; k < 6; k++) apply(mk(rb(), 1'(k & 1), ro(), rb(), ERB, 16'd0), "tmo_err");
    do_reset();
    apply(mk(0, 0, 4'h0, 0, NONE, 16'd0), "tmo_cleared");

    // Ack on the cycle the count reaches the limit wins.
    apply(mk(0, 1, 4'h0, 0, NONE, 16'd0), "ackwin_start");
    for (int k = 0; k < 14; k++) apply(mk(0, 0, 4'h0, 0, REQ, 16'd0), "ackwin_wait");
    apply(mk(1, 0, 4'h0, 0, REQ | IRW, 16'd0), "ackwin_ack");
    apply(mk(0, 0, 4'h3, 0, CTL, 16'd0), "ackwin_decode");

    // instret wraps, then asynchronous reset in the middle of a MEM handshake.
    do_reset();
    force dut.instret_q = 16'hFFFF;
    @(negedge clk);
    release dut.instret_q;
    apply(mk(0, 1, 4'h0, 0, NONE,      16'hFFFF), "wrap_idle");
    apply(mk(1, 0, 4'h0, 0, REQ | IRW, 16'hFFFF), "wrap_fetch");
    apply(mk(0, 0, 4'h4, 0, CTL,       16'hFFFF), "wrap_decode");
    apply(mk(0, 0, 4'h0, 0, ALU,       16'hFFFF), "wrap_exec");
    apply(mk(0, 0, 4'h0, 0, RFW | INC, 16'hFFFF), "wrap_wb");
    apply(mk(1, 0, 4'h0, 0, REQ | IRW, 16'h0000), "wrap_zero");
    apply(mk(0, 0, 4'hE, 0, CTL,       16'h0000), "rstmem_decode");
    apply(mk(0, 0, 4'h0, 0, ALU,       16'h0000), "rstmem_exec");
    apply(mk(0, 0, 4'h0, 0, REQ | SEL, 16'h0000), "rstmem_mem");
    #1 rst_n = 1'b0;
    #1 check_reset("async_reset_mem");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized instruction stream against the phase-level model.
    do_reset();
    mi = 16'd0;
    apply(mk(0, 1, ro(), rb(), NONE, mi), "rand_start");
    for (int n = 0; n < 300; n++) begin
      q.delete();
      gen_instr();
      while (q.size() > 0) apply(q.pop_front(), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/nr_sequencer.md
NR_SEQUENCER -- requirements
Module: nr_sequencer

Interface
REQ-001 Parameter TMO, default 15, memory-handshake timeout in cycles; 0 disables timeout.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  start from IDLE / wake from HALT; level-sampled.
REQ-005 opcode  input  4  instruction opcode field, valid from the cycle after ir_we.
REQ-006 alu_flag  input  1  branch condition result from ALU, valid in EXEC.
REQ-007 mem_ack  input  1  memory completion; one-cycle pulse or level.
REQ-008 mem_req  output  1  memory request, held until ack.
REQ-009 mem_we  output  1  memory write (sw data phase only).
REQ-010 mem_sel  output  1  address source: 0 = PC (fetch), 1 = ALU result (data).
REQ-011 ir_we, ctl_en, alu_en, rf_we, pc_inc, pc_load  output  1 each  one-cycle datapath strobes.
REQ-012 halted  output  1  high in HALT.
REQ-013 err  output  1  memory timeout, sticky.
REQ-014 instret  output  16  retired-instruction count.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; all strobes decoded from state and, where stated, mem_ack/alu_flag in the same cycle.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-017 FETCH: mem_req=1, mem_sel=0, mem_we=0; in the cycle mem_ack=1, ir_we=1 and next state DECODE.
REQ-018 DECODE (1 cycle): ctl_en=1; opcode SHALL be captured into internal op_q; op 0000 (slp) -> HALT with instret+1; otherwise -> EXEC.
REQ-019 EXEC (1 cycle): alu_en=1; op_q 1110/1111 (lw/sw) -> MEM; 0001/0010 (brq/brf) -> FETCH with pc_load=alu_flag, pc_inc=~alu_flag, instret+1; 1011 (jr) -> FETCH with pc_load=1, instret+1; all others -> WB.
REQ-020 MEM: mem_req=1, mem_sel=1, mem_we=(op_q==1111); on mem_ack: lw -> WB; sw -> FETCH with pc_inc=1, instret+1.
REQ-021 WB (1 cycle): rf_we=1, pc_inc=1, instret+1, -> FETCH.
REQ-022 pc_load and pc_inc SHALL never be high in the same cycle.
REQ-023 HALT: halted=1, all strobes 0; run=1 -> FETCH with pc_inc=1 in that cycle (skip slp word).
REQ-024 Timeout: counter cleared on entry to FETCH or MEM, increments each cycle waiting without ack; reaching TMO -> ERR, mem_req drops next cycle; ack in the same cycle as count reaching TMO wins (no error).
REQ-025 ERR: err=1, all strobes 0, run ignored; exit only by reset.
REQ-026 mem_ack outside FETCH/MEM SHALL be ignored; run outside IDLE/HALT SHALL be ignored.
REQ-027 instret SHALL wrap 0xFFFF -> 0x0000 without flag; increments at most once per cycle.
REQ-028 op_q SHALL hold stable from DECODE until next DECODE regardless of opcode input changes.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, all outputs 0 (halted=0, err=0, instret=0), timeout counter 0, op_q 0, including mid-handshake.
REQ-030 First rising clk after rst_n release SHALL evaluate IDLE transition rules only.

Verification
REQ-031 run=1, ack 1 cycle after each req, opcode 0011 -> FETCH,DECODE,EXEC,WB; rf_we and pc_inc high in WB; instret=1 after 5 cycles.
REQ-032 opcode 0001, alu_flag=1 -> pc_load=1, pc_inc=0 in EXEC; repeat alu_flag=0 -> pc_inc=1, pc_load=0; no WB.
REQ-033 opcode 1111 -> MEM with mem_sel=1, mem_we=1; ack after 3 cycles -> pc_inc pulse, back to FETCH, instret+1.
REQ-034 opcode 0000 -> halted=1 after DECODE, instret+1; hold run=0 10 cycles stays; run=1 -> pc_inc=1, FETCH.
REQ-035 TMO=15, no mem_ack in FETCH -> ERR after 15 waiting cycles, err=1; run toggling has no effect; rst_n=0 clears err.
REQ-036 instret preloaded to 0xFFFF via 65535 retires, one more add -> instret=0x0000; rst_n=0 during MEM -> mem_req=0 asynchronously, instret=0.
